// File: rtl/nibble_pkg.sv
// Shared widths, limits and FSM encoding for the nibble burst transmitter
// and its accumulator counterpart.
package nibble_pkg;

  localparam int X_W     = 4;
  localparam int Y_W     = 6;
  localparam int X_MAX   = (1 << X_W) - 1;
  localparam int BEATS_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAPW,
    DONE
  } state_t;

endpackage

// File: rtl/nibble_burst_tx_if.sv
// Request and sample-stream bundle of the nibble burst transmitter.
interface nibble_burst_tx_if #(
  parameter int X_W = nibble_pkg::X_W,
  parameter int Y_W = nibble_pkg::Y_W
) ();

  logic                           start;
  logic [Y_W-1:0]                 total;
  logic [X_W-1:0]                 x;
  logic                           x_is_valid;
  logic                           busy;
  logic                           done;
  logic [nibble_pkg::BEATS_W-1:0] beats;

  modport master (
    input  start, total,
    output x, x_is_valid, busy, done, beats
  );

  modport slave (
    output start, total,
    input  x, x_is_valid, busy, done, beats
  );

endinterface

// File: rtl/nibble_burst_tx_gap_timer.sv
// Loadable down-counter that holds the transmitter in GAPW for GAP cycles.
module gap_timer #(
  parameter int GAP = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expired
);

  localparam int CW = (GAP > 1) ? $clog2(GAP) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // Loaded with GAP-1 so expired is seen in the last gap cycle itself.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CW'(GAP - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/nibble_burst_tx.sv
// Splits a latched total into a greedy burst of X_MAX-limited samples whose
// sum equals the total; all outputs are registered.
module nibble_burst_tx #(
  parameter int X_W = nibble_pkg::X_W,
  parameter int Y_W = nibble_pkg::Y_W,
  parameter int GAP = 0
) (
  input  logic              clk,
  input  logic              rst,
  nibble_burst_tx_if.master bus
);

  import nibble_pkg::*;

  localparam logic [Y_W-1:0] SAMPLE_MAX = Y_W'((1 << X_W) - 1);

  state_t               state_q, state_d;
  logic [Y_W-1:0]       rem_q, rem_d;
  logic [X_W-1:0]       x_q, x_d;
  logic                 xv_q, xv_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [BEATS_W-1:0]   beats_q, beats_d;
  logic [Y_W-1:0]       rem_left;
  logic                 gap_expired;

  function automatic logic [Y_W-1:0] clip(input logic [Y_W-1:0] r);
    return (r > SAMPLE_MAX) ? SAMPLE_MAX : r;
  endfunction

  // Outputs are computed one cycle ahead so that each registered beat
  // appears in the cycle its state is occupied.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    beats_d  = beats_q;
    x_d      = '0;
    xv_d     = 1'b0;
    rem_left = rem_q - Y_W'(x_q);
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          rem_d   = bus.total;
          beats_d = '0;
          if (bus.total == '0) begin
            state_d = DONE;
          end else begin
            state_d = SEND;
            xv_d    = 1'b1;
            x_d     = X_W'(clip(bus.total));
          end
        end
      end
      SEND: begin
        rem_d   = rem_left;
        beats_d = beats_q + 1'b1;
        if (rem_left == '0) begin
          state_d = DONE;
        end else if (GAP > 0) begin
          state_d = GAPW;
        end else begin
          xv_d = 1'b1;
          x_d  = X_W'(clip(rem_left));
        end
      end
      GAPW: begin
        if (gap_expired) begin
          state_d = SEND;
          xv_d    = 1'b1;
          x_d     = X_W'(clip(rem_q));
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      x_q     <= '0;
      xv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      x_q     <= x_d;
      xv_q    <= xv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      beats_q <= beats_d;
    end
  end

  generate
    if (GAP > 0) begin : g_gap
      gap_timer #(
        .GAP(GAP)
      ) u_gap_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (state_q == SEND),
        .expired (gap_expired)
      );
    end else begin : g_no_gap
      assign gap_expired = 1'b1;
    end
  endgenerate

  assign bus.x          = x_q;
  assign bus.x_is_valid = xv_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.beats      = beats_q;

endmodule

// File: tb/tb_nibble_burst_tx.sv
// Scoreboard bench: GAP=0 and GAP=2 transmitters, directed bursts with
// hand-written beat lists, monitor checks value and cycle of every output.
module tb_nibble_burst_tx;

  import nibble_pkg::*;

  typedef struct {
    int cyc;
    bit is_done;
    int val;
  } exp_t;

  typedef int beat_list_t[5];

  logic clk = 1'b0;
  logic rst;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb0[$];
  exp_t sb2[$];

  nibble_burst_tx_if #(.X_W(X_W), .Y_W(Y_W)) if0 ();
  nibble_burst_tx_if #(.X_W(X_W), .Y_W(Y_W)) if2 ();

  nibble_burst_tx #(.X_W(X_W), .Y_W(Y_W), .GAP(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0.master)
  );

  nibble_burst_tx #(.X_W(X_W), .Y_W(Y_W), .GAP(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (if2.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int qsize(input int sel);
    return (sel == 0) ? sb0.size() : sb2.size();
  endfunction

  task automatic mon(input int sel, input logic xv, input logic [X_W-1:0] x,
                     input logic dn, input logic bsy, input logic [BEATS_W-1:0] bt);
    exp_t e;
    if (xv === 1'b1 || dn === 1'b1) begin
      if (qsize(sel) == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output dut%0d: x_is_valid=%0b done=%0b at cycle %0d, expected none",
                 sel, xv, dn, cyc);
      end else begin
        if (sel == 0) e = sb0.pop_front();
        else          e = sb2.pop_front();
        check($sformatf("dut%0d_event_cycle", sel), cyc, e.cyc);
        check($sformatf("dut%0d_event_is_done", sel), {31'b0, dn}, int'(e.is_done));
        check($sformatf("dut%0d_busy_in_burst", sel), {31'b0, bsy}, 1);
        if (e.is_done) check($sformatf("dut%0d_beats_at_done", sel), 32'(bt), e.val);
        else           check($sformatf("dut%0d_x", sel), 32'(x), e.val);
      end
    end else begin
      check($sformatf("dut%0d_x_idle_zero", sel), 32'(x), 0);
    end
  endtask

  always @(negedge clk) begin
    mon(0, if0.x_is_valid, if0.x, if0.done, if0.busy, if0.beats);
    mon(2, if2.x_is_valid, if2.x, if2.done, if2.busy, if2.beats);
  end

  // Beat k at E + k*(GAP+1); done one cycle after the last beat, or at E.
  task automatic push_exp(input int sel, input int e_cyc, input beat_list_t bl, output int n);
    exp_t e;
    n = 0;
    for (int k = 0; k < 5; k++) begin
      if (bl[k] != 0) begin
        e = '{e_cyc + k * (sel + 1), 1'b0, bl[k]};
        if (sel == 0) sb0.push_back(e);
        else          sb2.push_back(e);
        n++;
      end
    end
    e = '{(n == 0) ? e_cyc : e_cyc + (n - 1) * (sel + 1) + 1, 1'b1, n};
    if (sel == 0) sb0.push_back(e);
    else          sb2.push_back(e);
  endtask

  task automatic drive(input int sel, input logic st, input int tot);
    if (sel == 0) begin
      if0.start = st;
      if0.total = Y_W'(tot);
    end else begin
      if2.start = st;
      if2.total = Y_W'(tot);
    end
  endtask

  task automatic burst(input int sel, input int tot, input beat_list_t bl, output int n);
    int e_cyc;
    @(posedge clk);
    #1 drive(sel, 1'b1, tot);
    @(posedge clk);
    #1 e_cyc = cyc;
    drive(sel, 1'b0, tot);
    push_exp(sel, e_cyc, bl, n);
  endtask

  task automatic finish_burst(input int sel, input int n);
    for (int i = 0; i < 60 && qsize(sel) > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (qsize(sel) > 0) begin
      checks++;
      errors++;
      $display("FAIL dut%0d_drain_timeout: %0d events pending, expected 0", sel, qsize(sel));
      if (sel == 0) sb0.delete();
      else          sb2.delete();
    end
    @(negedge clk);
    #1;
    if (sel == 0) begin
      check("dut0_busy_after_done", {31'b0, if0.busy}, 0);
      check("dut0_beats_final", 32'(if0.beats), n);
    end else begin
      check("dut2_busy_after_done", {31'b0, if2.busy}, 0);
      check("dut2_beats_final", 32'(if2.beats), n);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_dut0_x"},     32'(if0.x), 0);
    check({tag, "_dut0_valid"}, {31'b0, if0.x_is_valid}, 0);
    check({tag, "_dut0_busy"},  {31'b0, if0.busy}, 0);
    check({tag, "_dut0_done"},  {31'b0, if0.done}, 0);
    check({tag, "_dut0_beats"}, 32'(if0.beats), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int e_cyc;
    rst = 1'b1;
    drive(0, 1'b0, 0);
    drive(2, 1'b0, 0);
    #2;
    check_zero_outputs("reset");
    check("reset_dut2_valid", {31'b0, if2.x_is_valid}, 0);
    check("reset_dut2_busy",  {31'b0, if2.busy}, 0);
    check("reset_dut2_beats", 32'(if2.beats), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    burst(0, 40, '{15, 15, 10, 0, 0}, n);  finish_burst(0, n);
    burst(0, 63, '{15, 15, 15, 15, 3}, n); finish_burst(0, n);
    burst(0, 30, '{15, 15, 0, 0, 0}, n);   finish_burst(0, n);
    burst(0, 0,  '{0, 0, 0, 0, 0}, n);     finish_burst(0, n);
    burst(2, 20, '{15, 5, 0, 0, 0}, n);    finish_burst(2, n);
    burst(2, 63, '{15, 15, 15, 15, 3}, n); finish_burst(2, n);
    burst(2, 0,  '{0, 0, 0, 0, 0}, n);     finish_burst(2, n);

    // start held high through a burst with total changed mid-burst
    @(posedge clk);
    #1 drive(0, 1'b1, 40);
    @(posedge clk);
    #1 e_cyc = cyc;
    push_exp(0, e_cyc, '{15, 15, 10, 0, 0}, n);
    push_exp(0, e_cyc + 5, '{5, 0, 0, 0, 0}, n);
    drive(0, 1'b1, 5);
    repeat (5) @(posedge clk);
    #1 drive(0, 1'b0, 5);
    finish_burst(0, n);

    // asynchronous reset after the second beat
    burst(0, 40, '{15, 15, 10, 0, 0}, n);
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    sb0.delete();
    #1;
    check_zero_outputs("async_rst");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    #1 check("abort_no_done_beats", 32'(if0.beats), 0);

    burst(0, 7, '{7, 0, 0, 0, 0}, n);      finish_burst(0, n);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
